mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 165 ++++++++++++++++
 tb/tb_mem_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
//==============================================================================
// Module   : mem_stage
// Purpose  : Fourth stage of the five-stage pipeline, between EX and WB.
//            Registers the EX result bundle, captures the synchronous
//            data-SRAM read data in the instruction's first MEM cycle and
//            holds it across WB back-pressure. Aligns and sign/zero-extends
//            load data, builds the WB bundle, and drives the MEM
//            forwarding/interlock bus to ID and the exception flag to EX.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            csr_reset           - exception/ertn flush from WB
//            EX_to_MEM_valid     - EX has an instruction ready to move
//            to_MEM_data         - EX result bundle
//            MEM_allow_in        - MEM can accept this cycle
//            data_sram_rdata     - SRAM read data (valid first MEM cycle)
//            WB_allow_in         - WB accepts this cycle
//            MEM_to_WB_valid     - MEM instruction transfers to WB
//            to_WB_data          - WB bundle
//            mem_ex              - valid MEM instruction is syscall/ertn
//            MEM_forward         - {dest, final_result, op_csr} to ID
// Revision : 1.0 - initial release
//==============================================================================

`ifndef CSR_NUM_WIDTH
`define CSR_NUM_WIDTH 14
`endif
`ifndef to_MEM_data_width
`define to_MEM_data_width (114 + `CSR_NUM_WIDTH)
`endif
`ifndef to_WB_data_width
`define to_WB_data_width (110 + `CSR_NUM_WIDTH)
`endif

module mem_stage (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           csr_reset,
    input  logic                           EX_to_MEM_valid,
    input  logic [`to_MEM_data_width-1:0]  to_MEM_data,
    output logic                           MEM_allow_in,
    input  logic [31:0]                    data_sram_rdata,
    input  logic                           WB_allow_in,
    output logic                           MEM_to_WB_valid,
    output logic [`to_WB_data_width-1:0]   to_WB_data,
    output logic                           mem_ex,
    output logic [37:0]                    MEM_forward
);

    localparam int c_CSRW = `CSR_NUM_WIDTH;

    logic                          r_valid;
    logic                          r_first;
    logic [31:0]                   r_rdata_buf;
    logic [`to_MEM_data_width-1:0] r_bundle;

    logic                          w_ready_go;
    logic                          w_accept;

    logic [31:0]                   w_pc;
    logic [31:0]                   w_alu_result;
    logic                          w_rd1;
    logic                          w_rd2;
    logic                          w_rd4;
    logic                          w_signed;
    logic [4:0]                    w_dest;
    logic                          w_gr_we;
    logic                          w_ex_sys;
    logic                          w_is_ertn;
    logic                          w_op_csr;
    logic [c_CSRW-1:0]             w_csr_num;
    logic [31:0]                   w_csr_wmask;
    logic [4:0]                    w_rj;

    logic [31:0]                   w_word;
    logic [7:0]                    w_byte;
    logic [15:0]                   w_half;
    logic [31:0]                   w_load_result;
    logic [31:0]                   w_final_result;

    // Bundle unpack, MSB first.
    assign {w_pc, w_alu_result, w_rd1, w_rd2, w_rd4, w_signed, w_dest, w_gr_we,
            w_ex_sys, w_is_ertn, w_op_csr, w_csr_num, w_csr_wmask, w_rj} = r_bundle;

    // MEM never needs more than one cycle.
    assign w_ready_go      = 1'b1;
    assign MEM_allow_in    = ~r_valid | (w_ready_go & WB_allow_in);
    assign MEM_to_WB_valid = r_valid & w_ready_go;
    assign w_accept        = EX_to_MEM_valid & MEM_allow_in;

    always_ff @(posedge clk) begin
        if (reset || csr_reset) begin
            r_valid <= 1'b0;
        end else if (MEM_allow_in) begin
            r_valid <= EX_to_MEM_valid;
        end
    end

    // Loads even under csr_reset; the contents are dead because r_valid clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bundle <= '0;
        end else if (w_accept) begin
            r_bundle <= to_MEM_data;
        end
    end

    // The SRAM returns data only in the cycle right after EX issued the read,
    // so r_first marks that cycle; afterwards the buffered copy is used.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_first <= 1'b0;
        end else if (w_accept) begin
            r_first <= 1'b1;
        end else if (r_valid) begin
            r_first <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata_buf <= 32'h0;
        end else if (r_valid && r_first) begin
            r_rdata_buf <= data_sram_rdata;
        end
    end

    assign w_word = r_first ? data_sram_rdata : r_rdata_buf;

    always_comb begin
        w_byte = w_word[7:0];
        case (w_alu_result[1:0])
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
    end

    // Half-word selection ignores alu_result[0]; misalignment is not trapped here.
    assign w_half = w_alu_result[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load_result = w_word;
        if (w_rd1) begin
            w_load_result = {{24{w_signed & w_byte[7]}}, w_byte};
        end else if (w_rd2) begin
            w_load_result = {{16{w_signed & w_half[15]}}, w_half};
        end
    end

    assign w_final_result = (w_rd1 | w_rd2 | w_rd4) ? w_load_result : w_alu_result;

    assign to_WB_data = {w_pc, w_final_result, w_dest, w_gr_we, w_ex_sys,
                         w_is_ertn, w_op_csr, w_csr_num, w_csr_wmask, w_rj};

    assign mem_ex = r_valid & (w_ex_sys | w_is_ertn);

    // A load result is already final in MEM, so no load-use bit is exported.
    assign MEM_forward = {w_dest & {5{r_valid & w_gr_we}},
                          w_final_result,
                          w_op_csr & r_valid};

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
//==============================================================================
// Module   : tb_mem_stage
// Purpose  : Directed self-checking bench for mem_stage.
// Revision : 1.0 - initial release
//==============================================================================

module tb_mem_stage;

    localparam int c_CSRW  = 14;
    localparam int c_MEM_W = 114 + c_CSRW;
    localparam int c_WB_W  = 110 + c_CSRW;

    logic               clk;
    logic               reset;
    logic               csr_reset;
    logic               EX_to_MEM_valid;
    logic [c_MEM_W-1:0] to_MEM_data;
    logic               MEM_allow_in;
    logic [31:0]        data_sram_rdata;
    logic               WB_allow_in;
    logic               MEM_to_WB_valid;
    logic [c_WB_W-1:0]  to_WB_data;
    logic               mem_ex;
    logic [37:0]        MEM_forward;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage u_dut (
        .clk             (clk),
        .reset           (reset),
        .csr_reset       (csr_reset),
        .EX_to_MEM_valid (EX_to_MEM_valid),
        .to_MEM_data     (to_MEM_data),
        .MEM_allow_in    (MEM_allow_in),
        .data_sram_rdata (data_sram_rdata),
        .WB_allow_in     (WB_allow_in),
        .MEM_to_WB_valid (MEM_to_WB_valid),
        .to_WB_data      (to_WB_data),
        .mem_ex          (mem_ex),
        .MEM_forward     (MEM_forward)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Fixed side fields: csr_num 0x5, csr_wmask 0xF0F0_0001, rj 3.
    function automatic logic [c_MEM_W-1:0] mk(
        input logic [31:0] pc, input logic [31:0] alu,
        input logic b1, input logic b2, input logic b4, input logic sg,
        input logic [4:0] dest, input logic we, input logic sys,
        input logic ertn, input logic opcsr);
        mk = {pc, alu, b1, b2, b4, sg, dest, we, sys, ertn, opcsr,
              14'h5, 32'hF0F0_0001, 5'd3};
    endfunction

    function automatic logic [c_WB_W-1:0] mkwb(
        input logic [31:0] pc, input logic [31:0] res, input logic [4:0] dest,
        input logic we, input logic sys, input logic ertn, input logic opcsr);
        mkwb = {pc, res, dest, we, sys, ertn, opcsr, 14'h5, 32'hF0F0_0001, 5'd3};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction from EX for a single cycle.
    task automatic send(input logic [c_MEM_W-1:0] b);
        EX_to_MEM_valid = 1'b1;
        to_MEM_data     = b;
        step();
        EX_to_MEM_valid = 1'b0;
    endtask

    function automatic logic [31:0] fres();
        fres = to_WB_data[91:60];
    endfunction

    initial begin
        reset = 1'b1; csr_reset = 1'b0; EX_to_MEM_valid = 1'b0;
        to_MEM_data = '0; data_sram_rdata = 32'h0; WB_allow_in = 1'b1;
        step(); step();
        reset = 1'b0;
        #1;
        chk("rst_valid",    128'(MEM_to_WB_valid), 128'(1'b0));
        chk("rst_mem_ex",   128'(mem_ex),          128'(1'b0));
        chk("rst_forward",  128'(MEM_forward),     128'(38'h0));
        chk("rst_allow_in", 128'(MEM_allow_in),    128'(1'b1));

        // ld.b, offset 2 -> byte 0x99 sign-extended
        send(mk(32'h1C00_0010, 32'h1000_0002, 1,0,0,1, 5'd4, 1, 0,0,0));
        data_sram_rdata = 32'h8899_AABB;
        #1;
        chk("ldb_valid", 128'(MEM_to_WB_valid), 128'(1'b1));
        chk("ldb_wb",    128'(to_WB_data),
            128'(mkwb(32'h1C00_0010, 32'hFFFF_FF99, 5'd4, 1, 0, 0, 0)));
        chk("ldb_fwd",   128'(MEM_forward), 128'({5'd4, 32'hFFFF_FF99, 1'b0}));
        step();
        chk("ldb_gone",  128'(MEM_to_WB_valid), 128'(1'b0));

        // ld.bu, offset 1 -> 0xAA zero-extended
        send(mk(32'h1C00_0014, 32'h1000_0001, 1,0,0,0, 5'd4, 1, 0,0,0));
        #1;
        chk("ldbu", 128'(fres()), 128'(32'h0000_00AA));
        step();

        // ld.h, offset 0 -> 0xAABB sign-extended
        send(mk(32'h1C00_0018, 32'h1000_0000, 0,1,0,1, 5'd5, 1, 0,0,0));
        #1;
        chk("ldh", 128'(fres()), 128'(32'hFFFF_AABB));
        step();

        // Back-to-back: ld.hu then ld.w with different first-cycle data
        send(mk(32'h1C00_0020, 32'h1000_0002, 0,1,0,0, 5'd6, 1, 0,0,0));
        data_sram_rdata = 32'h8899_AABB;
        EX_to_MEM_valid = 1'b1;
        to_MEM_data     = mk(32'h1C00_0024, 32'h1000_0004, 0,0,1,1, 5'd8, 1, 0,0,0);
        #1;
        chk("b2b_ldhu",  128'(fres()), 128'(32'h0000_8899));
        chk("b2b_allow", 128'(MEM_allow_in), 128'(1'b1));
        step();
        EX_to_MEM_valid = 1'b0;
        data_sram_rdata = 32'hCAFE_0001;
        #1;
        chk("b2b_ldw",   128'(fres()), 128'(32'hCAFE_0001));
        chk("b2b_pc",    128'(to_WB_data[123:92]), 128'(32'h1C00_0024));
        chk("b2b_valid", 128'(MEM_to_WB_valid), 128'(1'b1));
        step();

        // Stall hold: ld.w held for three cycles while rdata changes
        send(mk(32'h1C00_0030, 32'h2000_0000, 0,0,1,1, 5'd9, 1, 0,0,0));
        data_sram_rdata = 32'h1234_5678;
        WB_allow_in     = 1'b0;
        #1;
        chk("stall_first", 128'(fres()), 128'(32'h1234_5678));
        for (int i = 0; i < 3; i++) begin
            step();
            data_sram_rdata = 32'hDEAD_BEEF ^ 32'(i);
            #1;
            chk("stall_hold",  128'(fres()),          128'(32'h1234_5678));
            chk("stall_allow", 128'(MEM_allow_in),    128'(1'b0));
            chk("stall_valid", 128'(MEM_to_WB_valid), 128'(1'b1));
            chk("stall_fwd",   128'(MEM_forward),     128'({5'd9, 32'h1234_5678, 1'b0}));
        end
        WB_allow_in = 1'b1;
        #1;
        chk("stall_release", 128'(MEM_allow_in), 128'(1'b1));
        step();
        chk("stall_out", 128'(MEM_to_WB_valid), 128'(1'b0));

        // Non-load add with forwarding, then gr_we = 0, then op_csr
        send(mk(32'h1C00_0040, 32'h0000_0055, 0,0,0,0, 5'd7, 1, 0,0,0));
        data_sram_rdata = 32'hFFFF_FFFF;
        #1;
        chk("add_fwd", 128'(MEM_forward), 128'({5'd7, 32'h55, 1'b0}));
        step();
        send(mk(32'h1C00_0044, 32'h0000_0055, 0,0,0,0, 5'd7, 0, 0,0,0));
        #1;
        chk("add_nowe_fwd", 128'(MEM_forward), 128'({5'd0, 32'h55, 1'b0}));
        step();
        send(mk(32'h1C00_0048, 32'h0000_0066, 0,0,0,0, 5'd10, 1, 0,0,1));
        #1;
        chk("csr_fwd", 128'(MEM_forward), 128'({5'd10, 32'h66, 1'b1}));
        step();
        chk("idle_fwd", 128'(MEM_forward), 128'({5'd0, 32'h66, 1'b0}));

        // Syscall in MEM then csr_reset flush
        send(mk(32'h1C00_0050, 32'h0, 0,0,0,0, 5'd0, 0, 1,0,0));
        WB_allow_in = 1'b0;
        #1;
        chk("sys_mem_ex", 128'(mem_ex), 128'(1'b1));
        csr_reset = 1'b1;
        step();
        csr_reset = 1'b0;
        WB_allow_in = 1'b1;
        #1;
        chk("flush_valid",  128'(MEM_to_WB_valid), 128'(1'b0));
        chk("flush_mem_ex", 128'(mem_ex),          128'(1'b0));

        // ertn also raises mem_ex
        send(mk(32'h1C00_0054, 32'h0, 0,0,0,0, 5'd0, 0, 0,1,0));
        #1;
        chk("ertn_mem_ex", 128'(mem_ex), 128'(1'b1));
        step();

        // csr_reset coinciding with an EX transfer drops the instruction
        EX_to_MEM_valid = 1'b1;
        to_MEM_data     = mk(32'h1C00_0060, 32'h77, 0,0,0,0, 5'd11, 1, 0,0,0);
        csr_reset       = 1'b1;
        step();
        csr_reset = 1'b0;
        EX_to_MEM_valid = 1'b0;
        #1;
        chk("csr_drop_valid", 128'(MEM_to_WB_valid), 128'(1'b0));
        chk("csr_drop_fwd",   128'(MEM_forward[37:33]), 128'(5'd0));

        // Reset while a stalled load is held
        WB_allow_in = 1'b0;
        send(mk(32'h1C00_0070, 32'h3000_0000, 0,0,1,1, 5'd12, 1, 0,0,0));
        data_sram_rdata = 32'hABCD_0123;
        step();
        #1;
        chk("rst_stall_valid", 128'(MEM_to_WB_valid), 128'(1'b1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("rst_stall_drop", 128'(MEM_to_WB_valid), 128'(1'b0));
        chk("rst_stall_fwd",  128'(MEM_forward[37:33]), 128'(5'd0));
        chk("rst_stall_alw",  128'(MEM_allow_in), 128'(1'b1));
        WB_allow_in = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
